s_block_writer: RTL and testbench

Downstream neighbour of the matrix-multiply stage (Milestone 2, WS step). Takes one finished 8x8 block of S values from the dual-port S-RAM and clips each to 8 bits. Packs two pixels per 16-bit word and writes the 32 words into the Y, U or V output region of external SRAM. The block is driven by the matrix-multiply controller, which supplies the block row, block column and segment.

---
 rtl/s_block_writer.sv | 156 +++++++++++++++
 tb/tb_s_block_writer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_block_writer.sv
// Reads one 8x8 block of signed S values, clips each to 8 bits and writes the
// 32 packed pixel pairs into the Y/U/V region of external SRAM.
module s_block_writer #(
    parameter logic [17:0] Y_BASE       = 18'd0,
    parameter logic [17:0] U_BASE       = 18'd38400,
    parameter logic [17:0] V_BASE       = 18'd57600,
    parameter int unsigned Y_ROW_WORDS  = 160,
    parameter int unsigned UV_ROW_WORDS = 80
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        WS_start,
    input  logic [1:0]  seg_sel,
    input  logic [4:0]  block_row,
    input  logic [5:0]  block_col,
    output logic [5:0]  S_address_a,
    output logic [5:0]  S_address_b,
    input  logic [31:0] S_read_data_a,
    input  logic [31:0] S_read_data_b,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        WS_busy,
    output logic        WS_done
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_RD,
        LEAD_DATA,
        WRITE,
        DONE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_seg;
    logic [4:0]  r_row;
    logic [5:0]  r_col;
    logic [5:0]  r_k;

    logic [17:0] w_base;
    logic [17:0] w_row_words;
    logic [7:0]  w_img_row;
    logic [17:0] w_addr;
    logic [15:0] w_pack;
    logic [4:0]  w_rd_next;

    function automatic logic [7:0] clip8(input logic [31:0] v);
        if (v[31])
            return 8'h00;
        else if (|v[30:8])
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    // Constant row width, so this collapses to a fixed set of shifted adds.
    function automatic logic [17:0] shift_add(input logic [7:0] row, input logic [17:0] w);
        logic [17:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 18; i++) begin
            if (w[i])
                acc = acc + (18'(row) << i);
        end
        return acc;
    endfunction

    always_comb begin
        w_base      = Y_BASE;
        w_row_words = 18'(Y_ROW_WORDS);
        case (r_seg)
            2'd1: begin
                w_base      = U_BASE;
                w_row_words = 18'(UV_ROW_WORDS);
            end
            2'd2: begin
                w_base      = V_BASE;
                w_row_words = 18'(UV_ROW_WORDS);
            end
            default: ;
        endcase
    end

    // 8*RB + r and 4*CB + c are plain bit concatenations.
    assign w_img_row = {r_row, r_k[4:2]};
    assign w_addr    = w_base + shift_add(w_img_row, w_row_words) + 18'({r_col, r_k[1:0]});
    assign w_pack    = {clip8(S_read_data_a), clip8(S_read_data_b)};
    assign w_rd_next = r_k[4:0] + ((r_state == LEAD_RD) ? 5'd1 : 5'd2);

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_state         <= IDLE;
            r_seg           <= '0;
            r_row           <= '0;
            r_col           <= '0;
            r_k             <= '0;
            S_address_a     <= '0;
            S_address_b     <= '0;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            WS_busy         <= 1'b0;
            WS_done         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (WS_start && seg_sel != 2'd3) begin
                        r_seg       <= seg_sel;
                        r_row       <= block_row;
                        r_col       <= block_col;
                        r_k         <= '0;
                        S_address_a <= 6'd0;
                        S_address_b <= 6'd1;
                        WS_busy     <= 1'b1;
                        r_state     <= LEAD_RD;
                    end
                end
                LEAD_RD: begin
                    S_address_a <= {w_rd_next, 1'b0};
                    S_address_b <= {w_rd_next, 1'b1};
                    r_state     <= LEAD_DATA;
                end
                LEAD_DATA: begin
                    S_address_a     <= {w_rd_next, 1'b0};
                    S_address_b     <= {w_rd_next, 1'b1};
                    SRAM_address    <= w_addr;
                    SRAM_write_data <= w_pack;
                    SRAM_we_n       <= 1'b0;
                    r_k             <= r_k + 6'd1;
                    r_state         <= WRITE;
                end
                WRITE: begin
                    if (r_k[5]) begin
                        SRAM_we_n <= 1'b1;
                        WS_done   <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        S_address_a     <= {w_rd_next, 1'b0};
                        S_address_b     <= {w_rd_next, 1'b1};
                        SRAM_address    <= w_addr;
                        SRAM_write_data <= w_pack;
                        SRAM_we_n       <= 1'b0;
                        r_k             <= r_k + 6'd1;
                    end
                end
                DONE: begin
                    WS_done <= 1'b0;
                    WS_busy <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s_block_writer.sv
// Bench for s_block_writer: S-RAM model, write scoreboard, spot-check table
// and hand-written sequences for restart, illegal segment and reset.
module tb_s_block_writer;

    logic        clk = 1'b0;
    logic        Resetn;
    logic        WS_start;
    logic [1:0]  seg_sel;
    logic [4:0]  block_row;
    logic [5:0]  block_col;
    logic [5:0]  S_address_a, S_address_b;
    logic [31:0] S_read_data_a, S_read_data_b;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n, WS_busy, WS_done;

    s_block_writer dut (
        .CLOCK_50_I      (clk),
        .Resetn          (Resetn),
        .WS_start        (WS_start),
        .seg_sel         (seg_sel),
        .block_row       (block_row),
        .block_col       (block_col),
        .S_address_a     (S_address_a),
        .S_address_b     (S_address_b),
        .S_read_data_a   (S_read_data_a),
        .S_read_data_b   (S_read_data_b),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .WS_busy         (WS_busy),
        .WS_done         (WS_done)
    );

    always #10 clk = ~clk;

    logic [31:0] mem [64];
    always @(posedge clk) begin
        S_read_data_a <= mem[S_address_a];
        S_read_data_b <= mem[S_address_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;
    wr_t q[$];

    int          w_cnt, first_we, last_we, done_cnt, done_cyc, busy_cnt, busy_first;
    logic [17:0] log_addr [32];
    logic [15:0] log_data [32];

    task automatic clear_mon();
        w_cnt = 0; first_we = -1; last_we = -1; done_cnt = 0; done_cyc = -1;
        busy_cnt = 0; busy_first = -1;
    endtask

    always @(negedge clk) begin
        if (SRAM_we_n === 1'b0) begin
            if (w_cnt == 0) first_we = cyc;
            last_we = cyc;
            if (w_cnt < 32) begin
                log_addr[w_cnt] = SRAM_address;
                log_data[w_cnt] = SRAM_write_data;
            end
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got write addr %0d data 0x%h, required no write",
                         SRAM_address, SRAM_write_data);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", 32'(SRAM_address), 32'(e.addr));
                chk("wr_data", 32'(SRAM_write_data), 32'(e.data));
            end
            w_cnt++;
        end
        if (WS_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (WS_busy === 1'b1) begin
            if (busy_cnt == 0) busy_first = cyc;
            busy_cnt++;
        end
    end

    function automatic logic [7:0] ref_clip(input logic [31:0] v);
        if ($signed(v) < 0) return 8'd0;
        if ($signed(v) > 255) return 8'd255;
        return v[7:0];
    endfunction

    task automatic fill_mem(input int pat);
        for (int i = 0; i < 64; i++) begin
            case (pat)
                2: case (i % 4)
                       0: mem[i] = $urandom;
                       1: mem[i] = $urandom_range(0, 255);
                       2: mem[i] = $urandom_range(250, 300);
                       default: mem[i] = -$urandom_range(0, 10);
                   endcase
                default: mem[i] = i;
            endcase
        end
        if (pat == 1) begin
            mem[0] = -5;
            mem[1] = 300;
            mem[2] = 255;
            mem[3] = 32'h8000_0000;
        end
    endtask

    task automatic push_expected(input logic [1:0] seg, input logic [4:0] rb, input logic [5:0] cb);
        int base, w;
        base = (seg == 2'd0) ? 0 : (seg == 2'd1) ? 38400 : 57600;
        w    = (seg == 2'd0) ? 160 : 80;
        for (int k = 0; k < 32; k++) begin
            wr_t e;
            int  r, c, a;
            r = k / 4;
            c = k % 4;
            a = base + (8 * int'(rb) + r) * w + 4 * int'(cb) + c;
            e.addr = a[17:0];
            e.data = {ref_clip(mem[2*k]), ref_clip(mem[2*k+1])};
            q.push_back(e);
        end
    endtask

    // Start in cycle t, run through t+35, then check the block's timing.
    task automatic run_block(input logic [1:0] seg, input logic [4:0] rb, input logic [5:0] cb,
                             input int pat, input int pulse_at, input int rst_at);
        int t;
        @(posedge clk);
        #1;
        t = cyc;
        fill_mem(pat);
        clear_mon();
        push_expected(seg, rb, cb);
        WS_start = 1'b1; seg_sel = seg; block_row = rb; block_col = cb;
        for (int i = 1; i <= 35; i++) begin
            @(posedge clk);
            #1;
            WS_start = (i == pulse_at);
            if (i == 1) begin
                seg_sel = seg ^ 2'd1; block_row = ~rb; block_col = ~cb;
            end
            if (i == pulse_at) begin
                seg_sel = 2'd2; block_row = 5'd3; block_col = 6'd5;
            end
            if (i == rst_at) begin
                #4;
                Resetn = 1'b0;
                #1;
                chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
                chk("rst_busy", 32'(WS_busy), 32'd0);
            end
        end
        @(negedge clk);
        #1;
        if (rst_at == 0) begin
            chk("write_count", w_cnt, 32);
            chk("first_we_cycle", first_we, t + 3);
            chk("last_we_cycle", last_we, t + 34);
            chk("done_count", done_cnt, 1);
            chk("done_cycle", done_cyc, t + 35);
            chk("busy_cycles", busy_cnt, 35);
            chk("busy_first", busy_first, t + 1);
            chk("queue_left", q.size(), 0);
        end else begin
            chk("rst_write_count", w_cnt, 10);
            chk("rst_done_count", done_cnt, 0);
            q.delete();
            Resetn = 1'b1;
        end
    endtask

    typedef struct {
        logic [1:0]  seg;
        logic [4:0]  rb;
        logic [5:0]  cb;
        int          pat;
        int          i0;
        logic [17:0] a0;
        logic [15:0] d0;
        int          i1;
        logic [17:0] a1;
        logic [15:0] d1;
    } vec_t;
    vec_t tbl [6];

    initial begin
        tbl[0] = '{2'd0, 5'd0,  6'd0,  0, 0,  18'd0,     16'h0001, 3,  18'd3,     16'h0607};
        tbl[1] = '{2'd0, 5'd0,  6'd0,  0, 4,  18'd160,   16'h0809, 31, 18'd1123,  16'h3E3F};
        tbl[2] = '{2'd0, 5'd0,  6'd0,  1, 0,  18'd0,     16'h00FF, 1,  18'd1,     16'hFF00};
        tbl[3] = '{2'd0, 5'd29, 6'd39, 0, 0,  18'd37276, 16'h0001, 31, 18'd38399, 16'h3E3F};
        tbl[4] = '{2'd1, 5'd29, 6'd19, 0, 0,  18'd57036, 16'h0001, 31, 18'd57599, 16'h3E3F};
        tbl[5] = '{2'd2, 5'd0,  6'd0,  0, 0,  18'd57600, 16'h0001, 4,  18'd57680, 16'h0809};

        Resetn = 1'b0; WS_start = 1'b0; seg_sel = '0; block_row = '0; block_col = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        clear_mon();
        #35;
        chk("reset_we_n", 32'(SRAM_we_n), 32'd1);
        chk("reset_busy_done", {30'd0, WS_busy, WS_done}, 32'd0);
        chk("reset_sram", {14'd0, SRAM_address}, 32'd0);
        chk("reset_wdata", 32'(SRAM_write_data), 32'd0);
        chk("reset_saddr", {20'd0, S_address_a, S_address_b}, 32'd0);
        @(posedge clk);
        #1;
        Resetn = 1'b1;

        // Consecutive calls start the cycle after the previous WS_done.
        for (int v = 0; v < 6; v++) begin
            run_block(tbl[v].seg, tbl[v].rb, tbl[v].cb, tbl[v].pat, 0, 0);
            chk($sformatf("tbl%0d_addr_w%0d", v, tbl[v].i0), 32'(log_addr[tbl[v].i0]), 32'(tbl[v].a0));
            chk($sformatf("tbl%0d_data_w%0d", v, tbl[v].i0), 32'(log_data[tbl[v].i0]), 32'(tbl[v].d0));
            chk($sformatf("tbl%0d_addr_w%0d", v, tbl[v].i1), 32'(log_addr[tbl[v].i1]), 32'(tbl[v].a1));
            chk($sformatf("tbl%0d_data_w%0d", v, tbl[v].i1), 32'(log_data[tbl[v].i1]), 32'(tbl[v].d1));
        end

        run_block(2'd0, 5'd4, 6'd11, 2, 10, 0);

        @(posedge clk);
        #1;
        clear_mon();
        WS_start = 1'b1; seg_sel = 2'd3; block_row = 5'd1; block_col = 6'd1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            WS_start = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("seg3_writes", w_cnt, 0);
        chk("seg3_busy", busy_cnt, 0);
        chk("seg3_done", done_cnt, 0);

        run_block(2'd1, 5'd7, 6'd3, 2, 0, 13);
        repeat (3) @(posedge clk);
        run_block(2'd0, 5'd5, 6'd7, 2, 0, 0);
        run_block(2'd1, 5'd12, 6'd9, 2, 0, 0);
        run_block(2'd2, 5'd20, 6'd15, 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
